// File: rtl/gpr_scoreboard_rf.sv
// Register file with per-register busy scoreboard: two async read ports, one sync write port, r0 = 0.
// Optional write-to-read forwarding is enabled by defining GPR_BYPASS_EN.
module gpr_scoreboard_rf #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [DATA_W-1:0] rd_data1,
    output logic              rd_busy1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              rsv_conflict,
    input  logic              flush,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busyNext;
    logic [ADDR_W:0]   cntNext;
    logic              conflict;
    logic              rsvGrant;

    // A writeback to the reserved register frees it in the same cycle, so it is not a conflict.
    always_comb begin
        conflict = rsv_en & busy[rsv_addr] & ~(wr_en & (wr_addr == rsv_addr)) & (rsv_addr != '0);
        rsvGrant = rsv_en & ~conflict & (rsv_addr != '0) & ~flush;
    end

    assign rsv_conflict = conflict & ~rst;

    // Per-entry priority: flush, then reserve, then writeback clear, else hold.
    always_comb begin
        busyNext = busy;
        cntNext  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (flush) begin
                busyNext[i] = 1'b0;
            end else if (rsvGrant && (rsv_addr == ADDR_W'(i))) begin
                busyNext[i] = 1'b1;
            end else if (wr_en && (wr_addr == ADDR_W'(i))) begin
                busyNext[i] = 1'b0;
            end
        end
        busyNext[0] = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            cntNext = cntNext + (ADDR_W + 1)'(busyNext[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busyNext;
            busy_cnt <= cntNext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

`ifdef GPR_BYPASS_EN
    logic rdHit1;
    logic rdHit2;

    always_comb begin
        rdHit1 = wr_en & (wr_addr == rd_addr1) & (wr_addr != '0);
        rdHit2 = wr_en & (wr_addr == rd_addr2) & (wr_addr != '0);
        rd_data1 = '0;
        rd_busy1 = 1'b0;
        rd_data2 = '0;
        rd_busy2 = 1'b0;
        if (!rst) begin
            rd_data1 = rdHit1 ? wr_data : regs[rd_addr1];
            rd_busy1 = rdHit1 ? 1'b0    : busy[rd_addr1];
            rd_data2 = rdHit2 ? wr_data : regs[rd_addr2];
            rd_busy2 = rdHit2 ? 1'b0    : busy[rd_addr2];
        end
    end
`else
    always_comb begin
        rd_data1 = '0;
        rd_busy1 = 1'b0;
        rd_data2 = '0;
        rd_busy2 = 1'b0;
        if (!rst) begin
            rd_data1 = regs[rd_addr1];
            rd_busy1 = busy[rd_addr1];
            rd_data2 = regs[rd_addr2];
            rd_busy2 = busy[rd_addr2];
        end
    end
`endif

endmodule

// File: tb/tb_gpr_scoreboard_rf.sv
// Directed self-checking bench for gpr_scoreboard_rf; expectations queued on drive, popped on sample.
module tb_gpr_scoreboard_rf;

    logic        clk;
    logic        rst;
    logic [4:0]  rd_addr1;
    logic [31:0] rd_data1;
    logic        rd_busy1;
    logic [4:0]  rd_addr2;
    logic [31:0] rd_data2;
    logic        rd_busy2;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        rsv_conflict;
    logic        flush;
    logic [5:0]  busy_cnt;

    int checks;
    int failures;
    string       expTag [$];
    logic [63:0] expVal [$];

`ifdef GPR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    gpr_scoreboard_rf #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .rd_addr1(rd_addr1), .rd_data1(rd_data1), .rd_busy1(rd_busy1),
        .rd_addr2(rd_addr2), .rd_data2(rd_data2), .rd_busy2(rd_busy2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_conflict(rsv_conflict),
        .flush(flush), .busy_cnt(busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [63:0] val);
        expTag.push_back(tag);
        expVal.push_back(val);
    endtask

    task automatic pop(input logic [63:0] obs);
        string       tag;
        logic [63:0] exp;
        checks++;
        if (expVal.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty observed=%h expected=<queued value>", obs);
        end else begin
            tag = expTag.pop_front();
            exp = expVal.pop_front();
            assert (obs === exp) else begin
                failures++;
                $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
                $error("check %s mismatch", tag);
            end
        end
    endtask

    task automatic idle();
        wr_en = 1'b0; rsv_en = 1'b0; flush = 1'b0;
    endtask

    task automatic nextCycle();
        @(negedge clk);
        idle();
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1;
        rd_addr1 = '0; rd_addr2 = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;

        // reset state
        #7;
        push("rst_data1", 64'h0); push("rst_busy1", 64'h0); push("rst_conf", 64'h0); push("rst_cnt", 64'h0);
        pop(64'(rd_data1)); pop(64'(rd_busy1)); pop(64'(rsv_conflict)); pop(64'(busy_cnt));
        @(negedge clk); rst = 1'b0;

        // 1: write r5, read both ports
        nextCycle();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rd_addr1 = 5'd5; rd_addr2 = 5'd5;
        push("t1_same_cycle", BYP ? 64'hDEADBEEF : 64'h0);
        #1 pop(64'(rd_data1));
        nextCycle();
        push("t1_data1", 64'hDEADBEEF); push("t1_data2", 64'hDEADBEEF);
        push("t1_busy1", 64'h0); push("t1_busy2", 64'h0);
        #1 pop(64'(rd_data1)); pop(64'(rd_data2)); pop(64'(rd_busy1)); pop(64'(rd_busy2));

        // 2: write to r0 is dropped, no forwarding from r0
        nextCycle();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; rd_addr1 = 5'd0;
        push("t2_same_cycle", 64'h0);
        #1 pop(64'(rd_data1));
        nextCycle();
        push("t2_r0", 64'h0); push("t2_cnt", 64'h0);
        #1 pop(64'(rd_data1)); pop(64'(busy_cnt));

        // 3: reserve r7, conflict on re-reserve, writeback clears
        nextCycle();
        rsv_en = 1'b1; rsv_addr = 5'd7; rd_addr1 = 5'd7;
        push("t3_first_conf", 64'h0);
        #1 pop(64'(rsv_conflict));
        nextCycle();
        rsv_en = 1'b1; rsv_addr = 5'd7;
        push("t3_busy1", 64'h1); push("t3_cnt", 64'h1); push("t3_conf", 64'h1);
        #1 pop(64'(rd_busy1)); pop(64'(busy_cnt)); pop(64'(rsv_conflict));
        nextCycle();
        push("t3_cnt_after_conf", 64'h1);
        #1 pop(64'(busy_cnt));
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12;
        push("t3_wr_busy_same", BYP ? 64'h0 : 64'h1);
        #1 pop(64'(rd_busy1));
        nextCycle();
        push("t3_busy_clr", 64'h0); push("t3_cnt_clr", 64'h0); push("t3_data", 64'h12);
        #1 pop(64'(rd_busy1)); pop(64'(busy_cnt)); pop(64'(rd_data1));

        // 4: same-cycle write + reserve on r9, then again while r9 busy
        nextCycle();
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55; rsv_en = 1'b1; rsv_addr = 5'd9; rd_addr2 = 5'd9;
        push("t4_conf", 64'h0);
        #1 pop(64'(rsv_conflict));
        nextCycle();
        push("t4_data", 64'h55); push("t4_busy", 64'h1); push("t4_cnt", 64'h1);
        #1 pop(64'(rd_data2)); pop(64'(rd_busy2)); pop(64'(busy_cnt));
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h66; rsv_en = 1'b1; rsv_addr = 5'd9;
        push("t4_busy_wr_conf", 64'h0);
        #1 pop(64'(rsv_conflict));
        nextCycle();
        push("t4_data2", 64'h66); push("t4_busy2", 64'h1); push("t4_cnt2", 64'h1);
        #1 pop(64'(rd_data2)); pop(64'(rd_busy2)); pop(64'(busy_cnt));

        // 5: reserve r1..r4, then flush with rsv r6 and write r2
        for (int i = 1; i <= 4; i++) begin
            nextCycle();
            rsv_en = 1'b1; rsv_addr = 5'(i);
        end
        nextCycle();
        push("t5_cnt5", 64'd5);
        #1 pop(64'(busy_cnt));
        flush = 1'b1; rsv_en = 1'b1; rsv_addr = 5'd6; wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h77;
        rd_addr1 = 5'd6; rd_addr2 = 5'd2;
        nextCycle();
        push("t5_cnt0", 64'h0); push("t5_r6_busy", 64'h0); push("t5_r2_data", 64'h77); push("t5_r2_busy", 64'h0);
        #1 pop(64'(busy_cnt)); pop(64'(rd_busy1)); pop(64'(rd_data2)); pop(64'(rd_busy2));
        rsv_en = 1'b1; rsv_addr = 5'd0;
        push("t5_rsv_r0_conf", 64'h0);
        #1 pop(64'(rsv_conflict));
        nextCycle();
        push("t5_rsv_r0_cnt", 64'h0);
        #1 pop(64'(busy_cnt));

        // 6: write/read same cycle on r3, then async reset mid-cycle
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h11;
        nextCycle();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5; rd_addr2 = 5'd3;
        push("t6_same_data", BYP ? 64'hA5 : 64'h11); push("t6_same_busy", 64'h0);
        #1 pop(64'(rd_data2)); pop(64'(rd_busy2));
        nextCycle();
        push("t6_next_data", 64'hA5);
        #1 pop(64'(rd_data2));
        rsv_en = 1'b1; rsv_addr = 5'd8;
        nextCycle();
        rd_addr1 = 5'd8; rsv_en = 1'b1; rsv_addr = 5'd8; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hBB;
        push("t6_pre_rst_busy", 64'h1); push("t6_pre_rst_conf", 64'h1);
        #1 pop(64'(rd_busy1)); pop(64'(rsv_conflict));
        #1 rst = 1'b1;
        push("t6_rst_data2", 64'h0); push("t6_rst_busy1", 64'h0);
        push("t6_rst_conf", 64'h0); push("t6_rst_cnt", 64'h0);
        #1 pop(64'(rd_data2)); pop(64'(rd_busy1)); pop(64'(rsv_conflict)); pop(64'(busy_cnt));
        nextCycle();
        rst = 1'b0;
        rd_addr1 = 5'd5;
        push("t6_after_r5", 64'h0); push("t6_after_r3", 64'h0);
        #1 pop(64'(rd_data1)); pop(64'(rd_data2));
        nextCycle();
        push("t6_after_cnt", 64'h0); push("t6_after_busy8", 64'h0);
        rd_addr1 = 5'd8;
        #1 pop(64'(busy_cnt)); pop(64'(rd_busy1));

        checks++;
        assert (expVal.size() == 0) else begin
            failures++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", expVal.size());
            $error("check scoreboard_leftover mismatch");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
